// File: rtl/strip_trigger_candidate_builder.sv
`default_nettype none
// ============================================================================
// Module : strip_trigger_candidate_builder
// Majority-coincidence pad trigger builder feeding a show-ahead candidate FIFO.
// Rev    : 1.0
// ============================================================================
module strip_trigger_candidate_builder #(
  parameter int N_LAYERS   = 4,
  parameter int N_PADS     = 104,
  parameter int BAND_W     = 8,
  parameter int BCID_W     = 12,
  parameter int PHI_W      = 5,
  parameter int WIN_W      = 8,
  parameter int MAX_CAND   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_LAYERS*N_PADS-1:0]     pad_data,
  input  logic [N_LAYERS-1:0]            pad_data_valid,
  input  logic [BCID_W-1:0]              bcid,
  input  logic [WIN_W-1:0]               match_window,
  input  logic [$clog2(N_LAYERS+1)-1:0]  majority_thr,
  input  logic [N_LAYERS-1:0]            layer_enable,
  input  logic [PHI_W-1:0]               phi_id,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [BAND_W-1:0]              out_band_id,
  output logic [BCID_W-1:0]              out_bcid,
  output logic [PHI_W-1:0]               out_phi,
  output logic                           out_last,
  output logic                           busy,
  output logic [15:0]                    dropped_cnt,
  output logic [15:0]                    truncated_cnt
);

  localparam int c_thr_w  = $clog2(N_LAYERS+1);
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_emit_w = $clog2(MAX_CAND+1);
  localparam logic [N_PADS-1:0] c_one = N_PADS'(1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_EVAL = 2'd2, S_SCAN = 2'd3} state_t;

  state_t                      r_state;
  logic [N_LAYERS*N_PADS-1:0]  r_acc;
  logic [N_PADS-1:0]           r_match;
  logic [BCID_W-1:0]           r_bcid;
  logic [PHI_W-1:0]            r_phi;
  logic [c_thr_w-1:0]          r_thr;
  logic [N_LAYERS-1:0]         r_en;
  logic [WIN_W-1:0]            r_cnt;
  logic [c_emit_w-1:0]         r_emitted;
  logic [15:0]                 r_dropped;
  logic [15:0]                 r_truncated;

  logic [BAND_W-1:0]           r_mem_band [FIFO_DEPTH];
  logic [BCID_W-1:0]           r_mem_bcid [FIFO_DEPTH];
  logic [PHI_W-1:0]            r_mem_phi  [FIFO_DEPTH];
  logic                        r_mem_last [FIFO_DEPTH];
  logic [c_ptr_w-1:0]          r_wr_ptr;
  logic [c_ptr_w-1:0]          r_rd_ptr;
  logic [c_ptr_w:0]            r_count;

  logic [N_LAYERS-1:0]         w_hit_live;
  logic                        w_start;
  logic                        w_drop;
  logic [WIN_W-1:0]            w_win_eff;
  logic [c_thr_w-1:0]          w_thr_eff;
  logic [N_LAYERS*N_PADS-1:0]  w_in_live;
  logic [N_LAYERS*N_PADS-1:0]  w_in_lat;
  logic [N_PADS-1:0]           w_match;
  logic [BAND_W-1:0]           w_low;
  logic [N_PADS-1:0]           w_match_rest;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_push;
  logic                        w_last;

  function automatic logic [c_thr_w-1:0] count_ones(input logic [N_LAYERS-1:0] v);
    logic [c_thr_w-1:0] n;
    n = '0;
    for (int i = 0; i < N_LAYERS; i++) n = n + c_thr_w'(v[i]);
    return n;
  endfunction

  assign w_hit_live = pad_data_valid & layer_enable;
  assign w_start    = (r_state == S_IDLE) && (|w_hit_live);
  assign w_drop     = (|w_hit_live) && ((r_state == S_EVAL) || (r_state == S_SCAN));
  assign w_win_eff  = (match_window == '0) ? WIN_W'(1) : match_window;
  assign w_thr_eff  = (majority_thr == '0) ? c_thr_w'(1) : majority_thr;

  for (genvar l = 0; l < N_LAYERS; l++) begin : g_layer
    assign w_in_live[l*N_PADS +: N_PADS] = w_hit_live[l] ? pad_data[l*N_PADS +: N_PADS] : '0;
    assign w_in_lat[l*N_PADS +: N_PADS]  = (pad_data_valid[l] & r_en[l]) ?
                                           pad_data[l*N_PADS +: N_PADS] : '0;
  end

  for (genvar p = 0; p < N_PADS; p++) begin : g_pad
    logic [N_LAYERS-1:0] w_col;
    for (genvar l = 0; l < N_LAYERS; l++) begin : g_col
      assign w_col[l] = r_acc[l*N_PADS + p];
    end
    assign w_match[p] = (count_ones(w_col) >= r_thr);
  end

  // Priority encoder: lowest set pad wins, so candidates leave in ascending order.
  always_comb begin
    w_low = '0;
    for (int p = N_PADS-1; p >= 0; p--) begin
      if (r_match[p]) w_low = BAND_W'(p);
    end
  end

  assign w_match_rest = r_match & ~(c_one << w_low);
  assign w_full       = (r_count == (c_ptr_w+1)'(FIFO_DEPTH));
  assign w_pop        = out_valid & out_ready;
  assign w_push       = (r_state == S_SCAN) && (|r_match) && (!w_full || w_pop);
  assign w_last       = (w_match_rest == '0) || (r_emitted == c_emit_w'(MAX_CAND-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_match     <= '0;
      r_bcid      <= '0;
      r_phi       <= '0;
      r_thr       <= '0;
      r_en        <= '0;
      r_cnt       <= '0;
      r_emitted   <= '0;
      r_dropped   <= '0;
      r_truncated <= '0;
    end else begin
      if (w_drop && (r_dropped != 16'hFFFF)) r_dropped <= r_dropped + 16'd1;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_bcid    <= bcid;
            r_phi     <= phi_id;
            r_thr     <= w_thr_eff;
            r_en      <= layer_enable;
            r_acc     <= w_in_live;
            r_emitted <= '0;
            r_cnt     <= w_win_eff - WIN_W'(1);
            r_state   <= (w_win_eff == WIN_W'(1)) ? S_EVAL : S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_acc <= r_acc | w_in_lat;
          if (r_cnt <= WIN_W'(1)) r_state <= S_EVAL;
          else                    r_cnt   <= r_cnt - WIN_W'(1);
        end
        S_EVAL: begin
          r_match <= w_match;
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          if (r_match == '0) begin
            r_state <= S_IDLE;
          end else if (w_push) begin
            r_match   <= w_match_rest;
            r_emitted <= r_emitted + c_emit_w'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              if ((w_match_rest != '0) && (r_truncated != 16'hFFFF))
                r_truncated <= r_truncated + 16'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_band[i] <= '0;
        r_mem_bcid[i] <= '0;
        r_mem_phi[i]  <= '0;
        r_mem_last[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_mem_band[r_wr_ptr] <= w_low;
        r_mem_bcid[r_wr_ptr] <= r_bcid;
        r_mem_phi[r_wr_ptr]  <= r_phi;
        r_mem_last[r_wr_ptr] <= w_last;
        r_wr_ptr             <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_ptr_w+1)'(1);
        2'b01:   r_count <= r_count - (c_ptr_w+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign out_valid     = (r_count != '0);
  assign out_band_id   = r_mem_band[r_rd_ptr];
  assign out_bcid      = r_mem_bcid[r_rd_ptr];
  assign out_phi       = r_mem_phi[r_rd_ptr];
  assign out_last      = r_mem_last[r_rd_ptr];
  assign busy          = (r_state != S_IDLE);
  assign dropped_cnt   = r_dropped;
  assign truncated_cnt = r_truncated;

endmodule
`default_nettype wire

// File: doc/strip_trigger_candidate_builder.md
Name: strip_trigger_candidate_builder

Overview:
Parametrised next-generation strip trigger info builder. Collects time-aligned pad hit vectors from N_LAYERS TDS links over a configurable match window. Applies a programmable majority coincidence per pad position and emits up to MAX_CAND band-id candidates per event, each tagged with BCID and phi. Candidates go through a valid/ready FIFO to the strip trigger serializer. Sits between the link latency alignment stage and the trigger serializer, and replaces the fixed 4-layer path.

Parameters:
N_LAYERS, 4, number of pad links/layers
N_PADS, 104, pad bits per layer
BAND_W, 8, band id width; N_PADS <= 2**BAND_W
BCID_W, 12, BCID width
PHI_W, 5, phi id width
WIN_W, 8, match window counter width
MAX_CAND, 4, max candidates emitted per event
FIFO_DEPTH, 8, candidate FIFO depth (power of 2)

Ports:
clk  in  1  single clock
reset  in  1  asynchronous, active-low reset
pad_data  in  N_LAYERS*N_PADS  aligned hit vectors; layer l at [l*N_PADS +: N_PADS]
pad_data_valid  in  N_LAYERS  per-layer valid
bcid  in  BCID_W  current BCID
match_window  in  WIN_W  window length in cycles; 0 treated as 1
majority_thr  in  clog2(N_LAYERS+1)  min layers hit; 0 treated as 1
layer_enable  in  N_LAYERS  layer mask
phi_id  in  PHI_W  sector phi id
out_valid  out  1  candidate available
out_ready  in  1  consumer accept
out_band_id  out  BAND_W  pad index of candidate
out_bcid  out  BCID_W  event BCID
out_phi  out  PHI_W  latched phi id
out_last  out  1  last candidate of event
busy  out  1  state != IDLE
dropped_cnt  out  16  events arriving while busy, saturating
truncated_cnt  out  16  events cut at MAX_CAND, saturating

Behaviour:
- Reset (reset=0, async): state IDLE; FIFO flushed; out_valid=0; out_band_id/out_bcid/out_phi/out_last=0; busy=0; both counters=0. Reset mid-event discards all state.
- Event start: valid hit = |(pad_data_valid & layer_enable) in IDLE. That cycle (T):
  - latch bcid, phi_id, majority_thr, layer_enable, window.
  - acc[l] = pad_data_l if valid&enabled, else 0.
  - Latched config stays fixed until IDLE is re-entered.
- FSM IDLE -> COLLECT -> EVAL -> SCAN -> IDLE.
  - COLLECT: acc[l] |= pad_data_l for each valid enabled layer. Runs for window-1 cycles after T. Window=1 goes IDLE -> EVAL directly at T+1.
  - EVAL (1 cycle, at T+W): match[p] = popcount over l of acc[l][p] >= thr. Registered.
  - SCAN: each cycle with match!=0, FIFO not full and emitted<MAX_CAND:
    - push the lowest set index p with latched bcid/phi;
    - clear match[p]; emitted++.
    - out_last=1 on a push when the remaining match is 0 or emitted reaches MAX_CAND.
    - FIFO full: stall, no push, no clear.
  - SCAN -> IDLE when match==0 or emitted==MAX_CAND. If bits remain at MAX_CAND, truncated_cnt++.
  - Match==0 at SCAN entry: no push, IDLE next cycle.
- Latency: first push at T+W+1; out_valid rises at T+W+2 (FIFO registered, show-ahead). Throughput is 1 candidate/cycle when not backpressured.
- Drops: valid enabled hit in EVAL/SCAN, or in COLLECT's final cycle (never, since COLLECT absorbs), increments dropped_cnt once per cycle observed. Valid during COLLECT is absorbed, not dropped. Hit in the cycle SCAN exits is dropped (state not yet IDLE).
- FIFO handshake:
  - pop on out_valid&out_ready.
  - Simultaneous push and pop when full is allowed; push proceeds.
  - Outputs hold stable while out_valid&!out_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters saturate at 16'hFFFF.
- Disabled layers never contribute. layer_enable=0 means no event ever starts.

Test Plan:
- W=3, thr=3, layers 0,1,2 hit pad 17 at cycles T,T+1,T+2, bcid=0x123, phi=5 -> one candidate band 17, bcid 0x123, phi 5, out_last=1, out_valid at T+5.
- thr=2, layer0 pads {3,40,90}, layer1 pads {40,90}, W=1 -> candidates 40 then 90 on consecutive cycles; out_last on 90; pad 3 is not emitted.
- MAX_CAND=4, all 4 layers hit pads 0..9, thr=4 -> bands 0,1,2,3, last on 3; truncated_cnt=1.
- out_ready=0 with 10 matches, MAX_CAND=10, FIFO_DEPTH=8 -> 8 held, SCAN stalls, busy=1. Release ready -> bands 0..9 in order, no loss.
- Valid pulse during SCAN -> dropped_cnt=1, no extra candidates. layer_enable=4'b0111 with only layer3 hits -> no event.
- Assert reset low during SCAN with FIFO occupied -> out_valid=0 immediately, busy=0, counters 0. The next event after release behaves normally.
